// File: rtl/uart_pkg.sv
// Shared types and constants for the uart frame echo engine.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      APPEND_CR,
      APPEND_LF,
      SEND,
      DONE
   } state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Line-idle timeout in clock cycles, never below 2 so the timer has a real window.
   function automatic int idle_clks_calc(input int clk_freq, input int idle_us);
      int clks;
      clks = clk_freq / 1_000_000 * idle_us;
      return (clks < 2) ? 2 : clks;
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Frame storage: simple dual-port RAM, synchronous write, asynchronous read (LUT RAM).
module uart_frame_buf #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_echo.sv
// Frame buffer and echo engine: collects rx bytes into a frame, closes it on idle or LF,
// optionally appends CR LF and replays it through the uart_tx handshake.
//
//   state     | meaning
//   IDLE      | waiting for the first byte of a frame
//   COLLECT   | storing bytes, idle timer running
//   APPEND_CR | writing 0x0D after the frame
//   APPEND_LF | writing 0x0A after the frame
//   SEND      | replaying buffer bytes through tx_req/tx_done
//   DONE      | one-cycle frame wrap-up (stats, pointer clear)
module uart_frame_echo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int IDLE_US     = 1000,
   parameter int DEPTH       = 64,
   parameter int APPEND_CRLF = 1,
   parameter int EOL_MODE    = 0,
   parameter int AW          = $clog2(DEPTH)
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_vld,
   output logic [7:0]    tx_data,
   output logic          tx_req,
   input  logic          tx_done,
   output logic          busy,
   output logic [AW:0]   frame_len,
   output logic          frame_done,
   output logic [15:0]   frame_cnt,
   output logic          overflow,
   output logic          ovf_sticky
);

   localparam int IDLE_CLKS = idle_clks_calc(CLK_FREQ, IDLE_US);
   localparam int TW        = $clog2(IDLE_CLKS);
   localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_CLKS - 1);
   // Two slots are reserved for CR LF so the append states never overflow.
   localparam logic [AW:0] LIMIT = (APPEND_CRLF != 0) ? (AW+1)'(DEPTH - 2) : (AW+1)'(DEPTH);

   state_t        state, state_nxt;
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [TW-1:0] timer;
   logic          send_first;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    rd_data;
   logic          drop;
   logic          send_enter;
   logic          tx_load;
   logic          eol_hit;
   logic          can_store;

   uart_frame_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk   (sys_clk),
      .we    (mem_we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (mem_wdata),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      mem_we     = 1'b0;
      mem_wdata  = rx_data;
      drop       = 1'b0;
      tx_load    = 1'b0;
      eol_hit    = (EOL_MODE != 0) && (rx_data == ASCII_LF);
      can_store  = (wr_ptr < LIMIT);
      case (state)
         IDLE: begin
            if (rx_vld) begin
               mem_we    = 1'b1;
               state_nxt = eol_hit ? SEND : COLLECT;
            end
         end
         COLLECT: begin
            if (rx_vld) begin
               if (can_store) mem_we = 1'b1;
               else           drop   = 1'b1;
            end
            if (rx_vld && eol_hit)       state_nxt = SEND;
            else if (timer == TIMER_LAST) state_nxt = (APPEND_CRLF != 0) ? APPEND_CR : SEND;
         end
         APPEND_CR: begin
            mem_we    = 1'b1;
            mem_wdata = ASCII_CR;
            drop      = rx_vld;
            state_nxt = APPEND_LF;
         end
         APPEND_LF: begin
            mem_we    = 1'b1;
            mem_wdata = ASCII_LF;
            drop      = rx_vld;
            state_nxt = SEND;
         end
         SEND: begin
            drop = rx_vld;
            if (send_first) begin
               tx_load = 1'b1;
            end else if (tx_done) begin
               if (rd_ptr < wr_ptr) tx_load   = 1'b1;
               else                 state_nxt = DONE;
            end
         end
         DONE: begin
            drop      = rx_vld;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      send_enter = (state_nxt == SEND) && (state != SEND);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         timer      <= '0;
         send_first <= 1'b0;
         tx_req     <= 1'b0;
         tx_data    <= '0;
         frame_len  <= '0;
         frame_cnt  <= '0;
         overflow   <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         tx_req   <= 1'b0;
         overflow <= drop;
         if (drop) ovf_sticky <= 1'b1;

         if (state == COLLECT && !rx_vld) timer <= timer + TW'(1);
         else                             timer <= '0;

         if (state == DONE) begin
            wr_ptr    <= '0;
            frame_len <= wr_ptr;
            frame_cnt <= frame_cnt + 16'd1;
         end else if (mem_we) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end

         // First byte goes out one cycle after entry; later bytes follow each tx_done.
         if (send_enter) begin
            rd_ptr     <= '0;
            send_first <= 1'b1;
         end else if (tx_load) begin
            tx_req     <= 1'b1;
            tx_data    <= rd_data;
            rd_ptr     <= rd_ptr + (AW+1)'(1);
            send_first <= 1'b0;
         end
      end
   end

   assign busy       = (state == APPEND_CR) || (state == APPEND_LF) || (state == SEND) || (state == DONE);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_uart_frame_echo.sv
// Directed bench for uart_frame_echo: one CRLF-append instance and one EOL-mode instance,
// each with a uart_tx model returning tx_done 5 cycles after every tx_req.
module tb_uart_frame_echo;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data    [2];
   logic        rx_vld     [2];
   logic        tx_done    [2];
   logic [7:0]  tx_data    [2];
   logic        tx_req     [2];
   logic        busy       [2];
   logic [3:0]  frame_len  [2];
   logic        frame_done [2];
   logic [15:0] frame_cnt  [2];
   logic        overflow   [2];
   logic        ovf_sticky [2];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int last_strobe = 0;

   logic [7:0] txbuf  [2][64];
   int         reqcyc [2][64];
   int         txn [2];
   int         dn  [2];
   int         ovn [2];
   int         q   [2];
   int         proto_err = 0;
   int         stab_err = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_frame_echo #(
      .CLK_FREQ(1_000_000), .IDLE_US(10), .DEPTH(8), .APPEND_CRLF(1), .EOL_MODE(0)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .rx_data(rx_data[0]), .rx_vld(rx_vld[0]),
      .tx_data(tx_data[0]), .tx_req(tx_req[0]), .tx_done(tx_done[0]), .busy(busy[0]),
      .frame_len(frame_len[0]), .frame_done(frame_done[0]), .frame_cnt(frame_cnt[0]),
      .overflow(overflow[0]), .ovf_sticky(ovf_sticky[0])
   );

   uart_frame_echo #(
      .CLK_FREQ(1_000_000), .IDLE_US(10), .DEPTH(8), .APPEND_CRLF(1), .EOL_MODE(1)
   ) dut_eol (
      .sys_clk(clk), .sys_rst(rst), .rx_data(rx_data[1]), .rx_vld(rx_vld[1]),
      .tx_data(tx_data[1]), .tx_req(tx_req[1]), .tx_done(tx_done[1]), .busy(busy[1]),
      .frame_len(frame_len[1]), .frame_done(frame_done[1]), .frame_cnt(frame_cnt[1]),
      .overflow(overflow[1]), .ovf_sticky(ovf_sticky[1])
   );

   // uart_tx model and output monitor for both instances.
   initial begin
      for (int g = 0; g < 2; g++) begin
         txn[g] = 0; dn[g] = 0; ovn[g] = 0; q[g] = 0; tx_done[g] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            tx_done[g] = 1'b0;
            if (rst === 1'b1) q[g] = 0;
            if (q[g] > 0) begin
               q[g]--;
               if (q[g] == 0) begin
                  tx_done[g] = 1'b1;
                  if (txn[g] > 0 && tx_data[g] !== txbuf[g][txn[g]-1]) stab_err++;
               end
            end
            if (tx_req[g] === 1'b1) begin
               if (q[g] != 0) proto_err++;
               q[g] = 5;
               if (txn[g] < 64) begin
                  txbuf[g][txn[g]]  = tx_data[g];
                  reqcyc[g][txn[g]] = cyc;
                  txn[g]++;
               end
            end
            if (frame_done[g] === 1'b1) dn[g]++;
            if (overflow[g] === 1'b1) ovn[g]++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nclk();
      @(negedge clk);
      #1;
   endtask

   // Strobe one byte; successive calls put strobes exactly 'gap' cycles apart (gap >= 2).
   task automatic rx_byte(input int g, input logic [7:0] b, input int gap);
      nclk();
      rx_data[g] = b;
      rx_vld[g]  = 1'b1;
      last_strobe = cyc;
      nclk();
      rx_vld[g] = 1'b0;
      repeat (gap - 2) nclk();
   endtask

   task automatic wait_frame(input int g, input int tgt, input string tag);
      int i;
      i = 0;
      while (dn[g] < tgt && i < 300) begin
         nclk();
         i++;
      end
      chk({tag, "_done"}, dn[g], tgt);
      nclk();
   endtask

   task automatic check_tx(input int g, input int base, input string tag,
                           input logic [7:0] exp [8], input int n);
      chk({tag, "_ntx"}, txn[g] - base, n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_tx%0d", tag, i), txbuf[g][base+i], exp[i]);
   endtask

   initial begin
      int b0, o0, d0, s, i;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         rx_vld[g]  = 1'b0;
         rx_data[g] = 8'h00;
      end
      repeat (3) nclk();
      chk("rst_tx_req", tx_req[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_frame_len", frame_len[0], 0);
      chk("rst_frame_done", frame_done[0], 0);
      chk("rst_frame_cnt", frame_cnt[0], 0);
      chk("rst_overflow", overflow[0], 0);
      chk("rst_ovf_sticky", ovf_sticky[0], 0);
      chk("rst_eol_busy", busy[1], 0);
      rst = 1'b0;
      nclk();

      // Basic echo
      b0 = txn[0]; o0 = ovn[0]; d0 = dn[0];
      rx_byte(0, 8'h41, 3);
      rx_byte(0, 8'h42, 2);
      s = last_strobe;
      wait_frame(0, d0 + 1, "basic");
      check_tx(0, b0, "basic", '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
      chk("basic_len", frame_len[0], 4);
      chk("basic_cnt", frame_cnt[0], 1);
      chk("basic_lat", reqcyc[0][b0] - s, 14);
      chk("basic_busy_after", busy[0], 0);
      chk("basic_ovf", ovn[0] - o0, 0);

      // EOL mode
      b0 = txn[1]; d0 = dn[1];
      rx_byte(1, 8'h68, 3);
      rx_byte(1, 8'h0A, 2);
      s = last_strobe;
      wait_frame(1, d0 + 1, "eol");
      check_tx(1, b0, "eol", '{8'h68, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
      chk("eol_len", frame_len[1], 2);
      chk("eol_cnt", frame_cnt[1], 1);
      chk("eol_lat", reqcyc[1][b0] - s, 2);

      // Overflow
      b0 = txn[0]; o0 = ovn[0]; d0 = dn[0];
      for (int k = 0; k < 8; k++) rx_byte(0, 8'h30 + 8'(k), 2);
      wait_frame(0, d0 + 1, "ovf");
      chk("ovf_pulses", ovn[0] - o0, 2);
      chk("ovf_sticky", ovf_sticky[0], 1);
      check_tx(0, b0, "ovf", '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A}, 8);
      chk("ovf_len", frame_len[0], 8);
      chk("ovf_cnt", frame_cnt[0], 2);

      // Byte arriving during SEND is dropped
      b0 = txn[0]; o0 = ovn[0]; d0 = dn[0];
      rx_byte(0, 8'h51, 2);
      i = 0;
      while (txn[0] == b0 && i < 100) begin
         nclk();
         i++;
      end
      chk("drop_busy", busy[0], 1);
      rx_byte(0, 8'h55, 2);
      wait_frame(0, d0 + 1, "drop");
      chk("drop_ovf", ovn[0] - o0, 1);
      check_tx(0, b0, "drop", '{8'h51, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      chk("drop_cnt", frame_cnt[0], 3);

      b0 = txn[0]; d0 = dn[0];
      rx_byte(0, 8'h4E, 2);
      s = last_strobe;
      wait_frame(0, d0 + 1, "next");
      check_tx(0, b0, "next", '{8'h4E, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      chk("next_lat", reqcyc[0][b0] - s, 14);
      chk("next_cnt", frame_cnt[0], 4);

      // Byte coincident with timer expiry joins the frame
      b0 = txn[0]; d0 = dn[0];
      rx_byte(0, 8'h57, 10);
      rx_byte(0, 8'h58, 2);
      wait_frame(0, d0 + 1, "bnd");
      check_tx(0, b0, "bnd", '{8'h57, 8'h58, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
      chk("bnd_len", frame_len[0], 4);
      chk("bnd_cnt", frame_cnt[0], 5);

      // Reset in the middle of SEND
      b0 = txn[0];
      rx_byte(0, 8'h4B, 2);
      i = 0;
      while (txn[0] < b0 + 2 && i < 100) begin
         nclk();
         i++;
      end
      chk("rst_req2_seen", txn[0] - b0, 2);
      rst = 1'b1;
      nclk();
      chk("rst_mid_tx_req", tx_req[0], 0);
      chk("rst_mid_busy", busy[0], 0);
      chk("rst_mid_cnt", frame_cnt[0], 0);
      chk("rst_mid_sticky", ovf_sticky[0], 0);
      chk("rst_mid_len", frame_len[0], 0);
      rst = 1'b0;

      b0 = txn[0]; d0 = dn[0];
      rx_byte(0, 8'h5A, 2);
      wait_frame(0, d0 + 1, "post");
      check_tx(0, b0, "post", '{8'h5A, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
      chk("post_cnt", frame_cnt[0], 1);
      chk("post_len", frame_len[0], 3);

      chk("tx_handshake", proto_err, 0);
      chk("tx_data_stable", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
